// File: rtl/pic_ack_sequencer.sv
// pic_ack_sequencer: interrupt-acknowledge controller for the PIC.
// It resolves priority across masked IRR requests against the in-service
// register, raises int to the CPU and walks the two-pulse INTA handshake.
// Along the way it commits the winning level to ISR, strobes the IRR clear
// and drives the vector. It also services EOI commands and automatic EOI.
module pic_ack_sequencer #(
    parameter int VECTOR_W = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [7:0]          irr_i,
    input  logic                inta_i,
    input  logic                eoi_i,
    input  logic                eoi_specific_i,
    input  logic [2:0]          eoi_level_i,
    input  logic                aeoi_i,
    input  logic [4:0]          vector_base_i,
    output logic                int_o,
    output logic [7:0]          isr_o,
    output logic                reset_irr_bit_o,
    output logic [7:0]          irr_clear_mask_o,
    output logic [VECTOR_W-1:0] data_out_o,
    output logic                data_oe_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_ACK1  = 3'd2;
    localparam logic [2:0] S_WAIT2 = 3'd3;
    localparam logic [2:0] S_ACK2  = 3'd4;

    // Index of the lowest set bit (highest priority), or 8 when none is set.
    function automatic logic [3:0] lowest_idx(input logic [7:0] v);
        logic [3:0] idx;
        idx = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    logic [2:0]          state_q, state_d;
    logic                inta_dly_q;
    logic                int_q, int_d;
    logic [7:0]          isr_q, isr_d;
    logic                rst_irr_q, rst_irr_d;
    logic [7:0]          clr_mask_q, clr_mask_d;
    logic [VECTOR_W-1:0] dout_q, dout_d;
    logic                doe_q, doe_d;
    logic [2:0]          lvl_q, lvl_d;
    logic                spur_q, spur_d;

    logic [3:0]          req_idx;
    logic [3:0]          isr_idx;
    logic                qualified;
    logic                inta_rise;
    logic                inta_fall;
    logic [7:0]          isr_set;
    logic [7:0]          isr_clr;

    assign req_idx   = lowest_idx(irr_i);
    assign isr_idx   = lowest_idx(isr_q);
    assign qualified = (irr_i != 8'd0) && (req_idx < isr_idx);
    assign inta_rise = inta_i & ~inta_dly_q;
    assign inta_fall = ~inta_i & inta_dly_q;

    // Next-state, ISR update and registered-output decode for the handshake.
    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        spur_d     = spur_q;
        dout_d     = dout_q;
        rst_irr_d  = 1'b0;
        clr_mask_d = 8'd0;
        isr_set    = 8'd0;
        isr_clr    = 8'd0;

        // EOI is honoured in every state; the clear is applied before any set.
        if (eoi_i) begin
            if (eoi_specific_i) begin
                isr_clr = 8'd1 << eoi_level_i;
            end else if (isr_q != 8'd0) begin
                isr_clr = 8'd1 << isr_idx[2:0];
            end
        end

        case (state_q)
            S_IDLE, S_REQ: begin
                if (inta_rise) begin
                    state_d = S_ACK1;
                    if (irr_i != 8'd0) begin
                        lvl_d      = req_idx[2:0];
                        spur_d     = 1'b0;
                        isr_set    = 8'd1 << req_idx[2:0];
                        rst_irr_d  = 1'b1;
                        clr_mask_d = 8'd1 << req_idx[2:0];
                    end else begin
                        // Request vanished under the acknowledge: answer with level 7.
                        lvl_d  = 3'd7;
                        spur_d = 1'b1;
                    end
                end else if ((state_q == S_IDLE) && qualified) begin
                    state_d = S_REQ;
                end else if ((state_q == S_REQ) && !qualified) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK1: begin
                if (inta_fall) begin
                    state_d = S_WAIT2;
                end
            end
            S_WAIT2: begin
                if (inta_rise) begin
                    state_d = S_ACK2;
                    dout_d  = VECTOR_W'({vector_base_i, lvl_q});
                end
            end
            S_ACK2: begin
                if (inta_fall) begin
                    state_d = S_IDLE;
                    if (aeoi_i && !spur_q) begin
                        isr_clr = isr_clr | (8'd1 << lvl_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Set wins over a same-cycle clear of the same bit.
        isr_d = (isr_q & ~isr_clr) | isr_set;
        int_d = (state_d == S_REQ) || (state_d == S_ACK1) || (state_d == S_WAIT2);
        doe_d = (state_d == S_ACK2);
    end

    // State and output registers; reset forces IDLE and cancels any handshake at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            inta_dly_q <= 1'b0;
            int_q      <= 1'b0;
            isr_q      <= 8'd0;
            rst_irr_q  <= 1'b0;
            clr_mask_q <= 8'd0;
            dout_q     <= '0;
            doe_q      <= 1'b0;
            lvl_q      <= 3'd0;
            spur_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inta_dly_q <= inta_i;
            int_q      <= int_d;
            isr_q      <= isr_d;
            rst_irr_q  <= rst_irr_d;
            clr_mask_q <= clr_mask_d;
            dout_q     <= dout_d;
            doe_q      <= doe_d;
            lvl_q      <= lvl_d;
            spur_q     <= spur_d;
        end
    end

    assign int_o            = int_q;
    assign isr_o            = isr_q;
    assign reset_irr_bit_o  = rst_irr_q;
    assign irr_clear_mask_o = clr_mask_q;
    assign data_out_o       = dout_q;
    assign data_oe_o        = doe_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Scoreboard bench for pic_ack_sequencer: directed scenarios then random traffic.
module tb_pic_ack_sequencer;

    logic       clk = 1'b0;
    logic       reset_r = 1'b1;
    logic [7:0] irr = 8'd0;
    logic       inta = 1'b0;
    logic       eoi = 1'b0;
    logic       eoi_spec = 1'b0;
    logic [2:0] eoi_lvl = 3'd0;
    logic       aeoi = 1'b0;
    logic [4:0] vbase = 5'h08;

    logic       int_w;
    logic [7:0] isr_w;
    logic       strobe_w;
    logic [7:0] mask_w;
    logic [7:0] dout_w;
    logic       doe_w;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] q_mask[$];
    logic [7:0] q_vec[$];
    logic [7:0] m_isr = 8'd0;
    logic       prev_oe = 1'b0;
    logic [7:0] mon_exp;

    pic_ack_sequencer #(.VECTOR_W(8)) dut (
        .clk_i            (clk),
        .reset_i          (reset_r),
        .irr_i            (irr),
        .inta_i           (inta),
        .eoi_i            (eoi),
        .eoi_specific_i   (eoi_spec),
        .eoi_level_i      (eoi_lvl),
        .aeoi_i           (aeoi),
        .vector_base_i    (vbase),
        .int_o            (int_w),
        .isr_o            (isr_w),
        .reset_irr_bit_o  (strobe_w),
        .irr_clear_mask_o (mask_w),
        .data_out_o       (dout_w),
        .data_oe_o        (doe_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Isolates the highest-priority (lowest-index) request as a one-hot value.
    function automatic logic [7:0] low_bit(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    // A request interrupts when its one-hot is numerically below the ISR's one-hot.
    function automatic logic qual(input logic [7:0] r, input logic [7:0] s);
        return (r != 8'd0) && ((s == 8'd0) || (low_bit(r) < low_bit(s)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_irr(input logic [7:0] v);
        irr = v;
        tick();
        check("int_level", 32'(int_w), 32'(qual(v, m_isr)));
    endtask

    task automatic do_eoi(input logic spec, input logic [2:0] lvl);
        if (spec) m_isr = m_isr & ~(8'd1 << lvl);
        else      m_isr = m_isr & ~low_bit(m_isr);
        eoi = 1'b1; eoi_spec = spec; eoi_lvl = lvl;
        tick();
        eoi = 1'b0;
        check("isr_after_eoi", 32'(isr_w), 32'(m_isr));
    endtask

    task automatic handshake(input logic [7:0] irr_rise, input logic coll, input logic coll_spec,
                             input logic [2:0] coll_lvl, input logic abort);
        logic [7:0] oh;
        logic [7:0] clr;
        logic [2:0] lvl;
        logic       spur;
        logic [7:0] vexp;
        oh   = low_bit(irr_rise);
        spur = (irr_rise == 8'd0);
        lvl  = spur ? 3'd7 : 3'($clog2(oh));
        clr  = 8'd0;
        if (coll) clr = coll_spec ? (8'd1 << coll_lvl) : low_bit(m_isr);
        m_isr = (m_isr & ~clr) | oh;
        if (!spur) q_mask.push_back(oh);
        q_vec.push_back({vbase, lvl});

        irr = irr_rise; inta = 1'b1;
        eoi = coll; eoi_spec = coll_spec; eoi_lvl = coll_lvl;
        tick();
        eoi = 1'b0;
        check("isr_after_first_rise", 32'(isr_w), 32'(m_isr));
        irr = irr & ~oh;
        tick();
        inta = 1'b0;
        tick();
        tick();
        inta = 1'b1;
        tick();
        check("data_oe_second_rise", 32'(doe_w), 32'd1);
        check("int_in_ack2", 32'(int_w), 32'd0);
        if (abort) begin
            check("queued_vector_present", 32'(q_vec.size() != 0), 32'd1);
            if (q_vec.size() != 0) begin
                vexp = q_vec.pop_front();
                check("vector_before_reset", 32'(dout_w), 32'(vexp));
            end
            reset_r = 1'b1;
            #1;
            check("oe_async_reset", 32'(doe_w), 32'd0);
            check("int_async_reset", 32'(int_w), 32'd0);
            check("isr_async_reset", 32'(isr_w), 32'd0);
            m_isr = 8'd0;
            inta = 1'b0;
            tick();
            reset_r = 1'b0;
            tick();
        end else begin
            tick();
            inta = 1'b0;
            tick();
            check("data_oe_second_fall", 32'(doe_w), 32'd0);
            if (aeoi && !spur) m_isr = m_isr & ~oh;
            check("isr_after_second_fall", 32'(isr_w), 32'(m_isr));
            tick();
        end
    endtask

    // Monitor: every strobe and every vector presentation is matched against the scoreboard.
    always @(negedge clk) begin
        if (strobe_w) begin
            check("strobe_expected", 32'(q_mask.size() != 0), 32'd1);
            if (q_mask.size() != 0) begin
                mon_exp = q_mask.pop_front();
                check("irr_clear_mask", 32'(mask_w), 32'(mon_exp));
            end
        end
        if (doe_w && !prev_oe) begin
            check("vector_expected", 32'(q_vec.size() != 0), 32'd1);
            if (q_vec.size() != 0) begin
                mon_exp = q_vec.pop_front();
                check("vector", 32'(dout_w), 32'(mon_exp));
            end
        end
        prev_oe <= doe_w;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] rr;
        int         op;

        #12;
        check("reset_int", 32'(int_w), 32'd0);
        check("reset_isr", 32'(isr_w), 32'd0);
        check("reset_strobe", 32'(strobe_w), 32'd0);
        check("reset_mask", 32'(mask_w), 32'd0);
        check("reset_data_out", 32'(dout_w), 32'd0);
        check("reset_data_oe", 32'(doe_w), 32'd0);
        tick();
        reset_r = 1'b0;
        tick();

        // Basic handshake: level 2, vector 0x42.
        set_irr(8'h04);
        handshake(8'h04, 1'b0, 1'b0, 3'd0, 1'b0);
        check("basic_isr", 32'(isr_w), 32'h04);

        // Priority resolution and preemption.
        do_eoi(1'b0, 3'd0);
        set_irr(8'h90);
        handshake(8'h90, 1'b0, 1'b0, 3'd0, 1'b0);
        check("priority_isr", 32'(isr_w), 32'h10);
        set_irr(8'h20);
        check("lower_priority_blocked", 32'(int_w), 32'd0);
        set_irr(8'h08);
        check("preempt_int", 32'(int_w), 32'd1);
        handshake(8'h08, 1'b0, 1'b0, 3'd0, 1'b0);
        do_eoi(1'b0, 3'd0);
        set_irr(8'h04);
        handshake(8'h04, 1'b0, 1'b0, 3'd0, 1'b0);
        check("isr_before_eoi", 32'(isr_w), 32'h14);

        // EOI forms.
        do_eoi(1'b0, 3'd0);
        check("eoi_nonspecific", 32'(isr_w), 32'h10);
        do_eoi(1'b1, 3'd4);
        check("eoi_specific", 32'(isr_w), 32'h00);
        do_eoi(1'b0, 3'd0);
        check("eoi_empty", 32'(isr_w), 32'h00);

        // Automatic EOI.
        aeoi = 1'b1;
        set_irr(8'h01);
        handshake(8'h01, 1'b0, 1'b0, 3'd0, 1'b0);
        check("aeoi_isr", 32'(isr_w), 32'h00);
        aeoi = 1'b0;

        // Spurious acknowledge.
        set_irr(8'h02);
        handshake(8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        check("spurious_isr", 32'(isr_w), 32'h00);

        // Collision: EOI on level 2 with the set of level 2.
        set_irr(8'h04);
        handshake(8'h04, 1'b1, 1'b1, 3'd2, 1'b0);
        check("collision_isr", 32'(isr_w), 32'h04);

        // Reset during ACK2.
        set_irr(8'h01);
        handshake(8'h01, 1'b0, 1'b0, 3'd0, 1'b1);
        irr = 8'd0;
        tick();

        // Random traffic.
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 3));
            if (op <= 1) begin
                aeoi  = 1'($urandom_range(0, 1));
                vbase = 5'($urandom);
                v     = 8'($urandom);
                set_irr(v);
                if (qual(v, m_isr)) begin
                    rr = ($urandom_range(0, 7) == 0) ? 8'd0 : v;
                    handshake(rr, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                              3'($urandom_range(0, 7)), 1'b0);
                end
            end else if (op == 2) begin
                do_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            end else begin
                set_irr(8'($urandom) & 8'($urandom));
            end
        end

        irr = 8'd0;
        tick();
        tick();
        check("mask_queue_drained", 32'(q_mask.size()), 32'd0);
        check("vector_queue_drained", 32'(q_vec.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_ack_sequencer.md
# pic_ack_sequencer

Clocked interrupt-acknowledge controller for the programmable interrupt controller. It resolves priority among the masked requests presented by the IRR, compares them against its own in-service register (ISR), raises `int` to the CPU, and runs the two-pulse INTA handshake. Across that handshake it commits the winning level to ISR, issues the IRR clear strobe and drives the 8-bit vector. It also services end-of-interrupt (EOI) commands and automatic-EOI mode.

## Interface
- `VECTOR_W`, default 8: vector width; fixed at 8, with the upper 5 bits taken from `vector_base`.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `irr` in 8: pending requests from the IRR, already masked by IMR; bit 0 has the highest priority.
- `inta` in 1: CPU acknowledge, active-high level; edge-detected internally.
- `eoi` in 1: one-cycle EOI command strobe.
- `eoi_specific` in 1: qualifies `eoi`. 1 = specific EOI, 0 = non-specific EOI.
- `eoi_level` in 3: level to clear when an EOI is specific.
- `aeoi` in 1: static automatic-EOI mode enable.
- `vector_base` in 5: T7..T3 of the vector.
- `int` out 1: interrupt request to the CPU.
- `isr` out 8: in-service register.
- `reset_irr_bit` out 1: one-cycle strobe to the IRR.
- `irr_clear_mask` out 8: one-hot bit to clear; valid only while `reset_irr_bit`=1.
- `data_out` out 8: vector.
- `data_oe` out 1: vector bus enable.

## Operation
- Resolver (combinational):
  - `req_lvl` = lowest index set in `irr`.
  - `isr_lvl` = lowest index set in `isr`, or 8 if `isr`=0.
  - `qualified` = (`irr`≠0) and (`req_lvl` < `isr_lvl`).
- INTA edges: an internal register `inta_d` tracks `inta`.
  - Rise = `inta` & ~`inta_d`.
  - Fall = ~`inta` & `inta_d`.
- IDLE
  - `qualified` → REQ.
  - Rise → ACK1 (same actions as the REQ rise).
- REQ (`int`=1)
  - `qualified` drops → IDLE; `int` deasserts.
  - Rise → ACK1, with these actions:
    - Latch `lvl` = `req_lvl`.
    - Set `isr[lvl]`.
    - Pulse `reset_irr_bit` with `irr_clear_mask` = 1<<`lvl`.
  - Rise with `irr`=0 is spurious: `lvl`=7, ISR unchanged, no IRR strobe, `spurious` flag set.
- ACK1 (`int` stays 1, `data_oe`=0)
  - Fall → WAIT2.
- WAIT2
  - Rise → ACK2: `data_oe`=1, `data_out` = {`vector_base`, `lvl`}; `int` deasserts.
- ACK2
  - Fall → IDLE; `data_oe`=0.
  - If `aeoi`=1 and not spurious, clear `isr[lvl]` on that fall.
- EOI is accepted in any state.
  - Non-specific: clears `isr[isr_lvl]`; no effect if `isr`=0.
  - Specific: clears `isr[eoi_level]`.
- The ISR set from an INTA rise and an EOI clear in the same cycle:
  - Apply the clear first, then the set.
  - If both target the same bit, the set wins.
- Rotation, cascade and poll modes are not supported by this block.

## Timing
- All outputs are registered, and each output reflects the state of its state bit.
- Reset values:
  - State IDLE.
  - `int`=0, `isr`=0, `reset_irr_bit`=0, `irr_clear_mask`=0, `data_out`=0, `data_oe`=0, `inta_d`=0.
  - `lvl`=0, `spurious`=0.
- `int` rises 1 cycle after `qualified` first holds in IDLE.
- `int` falls 1 cycle after `qualified` drops in REQ.
- `isr` and `reset_irr_bit` update 1 cycle after the edge where the first INTA rise is sampled. `reset_irr_bit` is high for exactly 1 cycle.
- `data_oe` rises 1 cycle after the second rise is sampled and falls 1 cycle after the second fall is sampled.
- AEOI clear lands on that same edge as the `data_oe` fall.
- `inta` must be synchronous to `clk` and held at least 1 cycle per level. Shorter glitches are not guaranteed to be seen.
- `reset` asserted mid-sequence forces IDLE and the reset values immediately (asynchronously). No vector or strobe completes.
- A higher-priority request arriving in ACK1/WAIT2 does not change `lvl`. It is re-resolved only after returning to IDLE.

## Test plan
- Basic handshake:
  - Stimulus: reset; `vector_base`=5'h08; `irr`=8'b0000_0100; two INTA pulses of 2 cycles each.
  - Response: `int`=1; after the first rise `isr`=8'h04 and a 1-cycle `reset_irr_bit` with mask 8'h04; during the second pulse `data_out`=8'h42, `data_oe`=1; `isr` stays 8'h04.
- Priority:
  - Stimulus: `irr`=8'h90.
  - Response: `lvl`=4, vector {base,3'd4}, `isr`=8'h10.
  - Stimulus: then `irr`=8'h20 with `isr`=8'h10.
  - Response: `int` stays 0. Raising `irr`=8'h08 gives `int`=1 (level 3 preempts).
- EOI:
  - Stimulus: `isr`=8'h14, non-specific EOI.
  - Response: `isr`=8'h10.
  - Stimulus: specific EOI with `eoi_level`=4.
  - Response: `isr`=8'h00.
  - Stimulus: non-specific EOI with `isr`=0.
  - Response: no change.
- AEOI:
  - Stimulus: `aeoi`=1, `irr`=8'h01, full handshake.
  - Response: `isr`=8'h01 after the first pulse; `isr`=8'h00 one cycle after the second fall.
- Spurious:
  - Stimulus: `irr`=8'h02 raises `int`, `irr` drops to 0 in the same cycle the first INTA rise is sampled.
  - Response: no ISR change, no `reset_irr_bit`; vector {base,3'd7}.
- Reset mid-sequence and collision:
  - Stimulus: assert `reset` during ACK2.
  - Response: `data_oe`, `int`, `isr` go to 0 immediately; state IDLE.
  - Stimulus: EOI specific level 2 in the same cycle as the first INTA rise for level 2.
  - Response: `isr[2]`=1.
